// File: rtl/peripheral_divn_if.sv
// Register bus between a host and the peripheral_divn divider.
// The master drives the strobes, address and write data; the slave returns read data.
interface peripheral_divn_if;
  logic [31:0] d_in;
  logic        cs;
  logic [4:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;

  modport master (output d_in, cs, addr, rd, wr, input d_out);
  modport slave  (input d_in, cs, addr, rd, wr, output d_out);
endinterface

// File: rtl/peripheral_divn.sv
// Memory-mapped restoring divider, signed or unsigned, one quotient bit per clock.
//   state | meaning
//   IDLE  | after reset, waiting for a start
//   CALC  | shift-subtract on operand magnitudes, WIDTH cycles
//   FIX   | sign correction, load QUOT/REM
//   DONE  | result valid, waiting for the next start
module peripheral_divn #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         reset,
  peripheral_divn_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dividend_r, divisor_r, quot_r, rem_r;
  logic [WIDTH-1:0] q_work, r_work, b_mag;
  logic [CW-1:0]    cnt;
  logic             signed_r, done_r, div_zero_r, neg_q, neg_r;

  logic             busy, wr_en, start, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   trial;
  logic [31:0]      rd_data;
  logic             unused_din;

  assign busy  = (state == CALC) || (state == FIX);
  assign wr_en = bus.cs && bus.wr;
  assign start = wr_en && (bus.addr == 5'h08) && bus.d_in[0] &&
                 ((state == IDLE) || (state == DONE));

  // Sign mode comes from the CTRL write itself, so operand signs are judged on the start edge.
  assign a_neg = bus.d_in[1] && dividend_r[WIDTH-1];
  assign b_neg = bus.d_in[1] && divisor_r[WIDTH-1];
  assign a_abs = a_neg ? ((~dividend_r) + WIDTH'(1)) : dividend_r;
  assign b_abs = b_neg ? ((~divisor_r) + WIDTH'(1)) : divisor_r;
  assign trial = {r_work, q_work[WIDTH-1]};

  assign unused_din = ^bus.d_in;

  always_comb begin
    rd_data = 32'd0;
    if (bus.cs && bus.rd) begin
      case (bus.addr)
        5'h00:   rd_data = 32'(dividend_r);
        5'h04:   rd_data = 32'(divisor_r);
        5'h0C:   rd_data = {28'd0, signed_r, div_zero_r, done_r, busy};
        5'h10:   rd_data = 32'(quot_r);
        5'h14:   rd_data = 32'(rem_r);
        default: rd_data = 32'd0;
      endcase
    end
  end
  assign bus.d_out = rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dividend_r <= '0;
      divisor_r  <= '0;
      quot_r     <= '0;
      rem_r      <= '0;
      q_work     <= '0;
      r_work     <= '0;
      b_mag      <= '0;
      cnt        <= '0;
      signed_r   <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else begin
      if (wr_en && !busy) begin
        if (bus.addr == 5'h00) dividend_r <= bus.d_in[WIDTH-1:0];
        if (bus.addr == 5'h04) divisor_r  <= bus.d_in[WIDTH-1:0];
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            signed_r <= bus.d_in[1];
            if (divisor_r == '0) begin
              done_r     <= 1'b1;
              div_zero_r <= 1'b1;
              quot_r     <= '1;
              rem_r      <= dividend_r;
              state      <= DONE;
            end else begin
              done_r     <= 1'b0;
              div_zero_r <= 1'b0;
              q_work     <= a_abs;
              b_mag      <= b_abs;
              r_work     <= '0;
              neg_q      <= a_neg ^ b_neg;
              neg_r      <= a_neg;
              cnt        <= CW'(WIDTH);
              state      <= CALC;
            end
          end
        end

        CALC: begin
          // Quotient bits shift into q_work from the right as dividend bits leave on the left.
          if (trial >= {1'b0, b_mag}) begin
            r_work <= trial[WIDTH-1:0] - b_mag;
            q_work <= {q_work[WIDTH-2:0], 1'b1};
          end else begin
            r_work <= trial[WIDTH-1:0];
            q_work <= {q_work[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end

        FIX: begin
          quot_r <= neg_q ? ((~q_work) + WIDTH'(1)) : q_work;
          rem_r  <= neg_r ? ((~r_work) + WIDTH'(1)) : r_work;
          done_r <= 1'b1;
          state  <= DONE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
